// File: rtl/result_drain.sv
// ============================================================================
// result_drain : captures the systolic array result tile, clears the array,
//                and streams the tile out one row/column per beat.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module result_drain #(
    parameter int N         = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int STRIDE    = 1,
    parameter int TRANSPOSE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  array_ready,
    input  logic [N*N*DATA_W-1:0] array_out,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  array_clear,
    output logic [N*DATA_W-1:0]   row_data,
    output logic [ADDR_W-1:0]     row_addr,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  c_last   = IDX_W'(N - 1);
    localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ready_q;
    logic                r_clear;
    logic                r_overrun;
    logic [IDX_W-1:0]    r_index;
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_buf [N][N];
    logic [N*DATA_W-1:0] w_row;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_event;
    logic                w_capture;

    assign w_event   = array_ready && !r_ready_q;
    assign w_capture = w_event && (r_state == S_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_capture) w_state_next = S_STREAM;
            S_STREAM: if (row_ready && (r_index == c_last)) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ready_q <= 1'b0;
            r_clear   <= 1'b0;
            r_overrun <= 1'b0;
            r_index   <= '0;
            r_base    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ready_q <= array_ready;
            r_clear   <= w_capture;
            // Rising edges outside IDLE are dropped, never queued.
            if (w_event && (r_state != S_IDLE)) r_overrun <= 1'b1;
            if (w_capture) begin
                r_index <= '0;
                r_base  <= base_addr;
            end else if ((r_state == S_STREAM) && row_ready && (r_index != c_last)) begin
                r_index <= r_index + IDX_W'(1);
            end
        end
    end

    // Buffer carries no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_buf[i][j] <= array_out[(i*N+j)*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar e = 0; e < N; e++) begin : g_elem
        if (TRANSPOSE != 0) begin : g_col
            assign w_row[e*DATA_W +: DATA_W] = r_buf[e][r_index];
        end else begin : g_row
            assign w_row[e*DATA_W +: DATA_W] = r_buf[r_index][e];
        end
    end

    assign w_addr      = r_base + ADDR_W'(r_index) * c_stride;
    assign row_valid   = (r_state == S_STREAM);
    assign row_data    = row_valid ? w_row  : '0;
    assign row_addr    = row_valid ? w_addr : '0;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign array_clear = r_clear;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_result_drain.sv
// ============================================================================
// tb_result_drain : directed scoreboard bench for result_drain, run on a
//                   row-mode/stride-1 and a column-mode/stride-4 instance.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_result_drain;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;

    typedef struct packed {
        logic [N*DW-1:0] d;
        logic [AW-1:0]   a;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              array_ready;
    logic [N*N*DW-1:0] array_out;
    logic [AW-1:0]     base_addr;
    logic              row_ready;

    logic              clear0, valid0, busy0, done0, ovr0;
    logic [N*DW-1:0]   data0;
    logic [AW-1:0]     addr0;
    logic              clear1, valid1, busy1, done1, ovr1;
    logic [N*DW-1:0]   data1;
    logic [AW-1:0]     addr1;

    logic [DW-1:0]     mat [N][N];
    beat_t             q0[$];
    beat_t             q1[$];
    int                checks = 0;
    int                errors = 0;
    logic [N*DW-1:0]   held_d;
    logic [AW-1:0]     held_a;

    always #5 clk = ~clk;

    result_drain #(.N(N), .DATA_W(DW), .ADDR_W(AW), .STRIDE(1), .TRANSPOSE(0)) dut0 (
        .clk(clk), .rst(rst), .array_ready(array_ready), .array_out(array_out),
        .base_addr(base_addr), .array_clear(clear0), .row_data(data0), .row_addr(addr0),
        .row_valid(valid0), .row_ready(row_ready), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    result_drain #(.N(N), .DATA_W(DW), .ADDR_W(AW), .STRIDE(4), .TRANSPOSE(1)) dut1 (
        .clk(clk), .rst(rst), .array_ready(array_ready), .array_out(array_out),
        .base_addr(base_addr), .array_clear(clear1), .row_data(data1), .row_addr(addr1),
        .row_valid(valid1), .row_ready(row_ready), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    // IEEE-754 single encoding of a small non-negative integer.
    function automatic logic [31:0] fb(input int v);
        int p;
        if (v == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 31; b++) if (v[b]) p = b;
        return {1'b0, 8'(127 + p), 23'((v << (23 - p)) & 32'h007F_FFFF)};
    endfunction

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load_mat(input int off);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mat[i][j] = fb(off + 10*i + j);
                array_out[(i*N+j)*DW +: DW] = mat[i][j];
            end
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] base);
        beat_t b0, b1;
        for (int k = 0; k < N; k++) begin
            for (int e = 0; e < N; e++) begin
                b0.d[e*DW +: DW] = mat[k][e];
                b1.d[e*DW +: DW] = mat[e][k];
            end
            b0.a = AW'(base + AW'(k));
            b1.a = AW'(base + AW'(4*k));
            q0.push_back(b0);
            q1.push_back(b1);
        end
    endtask

    // Pop/compare accepted beats, then advance to the next negedge.
    task automatic step();
        beat_t e;
        if (valid0 && row_ready) begin
            chk1("sb0_nonempty", q0.size() != 0, 1'b1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("beat0_data", data0, e.d);
                chk16("beat0_addr", addr0, e.a);
            end
        end
        if (valid1 && row_ready) begin
            chk1("sb1_nonempty", q1.size() != 0, 1'b1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("beat1_data", data1, e.d);
                chk16("beat1_addr", addr1, e.a);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic capture(input int off, input logic [AW-1:0] base);
        array_ready = 1'b0;
        step();
        load_mat(off);
        base_addr   = base;
        array_ready = 1'b1;
        push_exp(base);
        step();
    endtask

    initial begin
        rst = 1'b1; array_ready = 1'b0; array_out = '0; base_addr = '0; row_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk1("rst_clear", clear0, 1'b0);
        chk1("rst_valid", valid0, 1'b0);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_done", done0, 1'b0);
        chk1("rst_overrun", ovr0, 1'b0);
        chk("rst_data", data0, '0);
        chk16("rst_addr", addr0, 16'h0);
        rst = 1'b0;

        // Timing, row/column content, array_ready held high throughout.
        capture(0, 16'h0100);
        for (int c = 1; c <= 5; c++) begin
            chk1("s1_clear", clear0, c == 1);
            chk1("s1_valid", valid0, c <= 4);
            chk1("s1_done", done0, c == 5);
            chk1("s1_busy", busy0, 1'b1);
            if (c == 2) begin
                chk("t1_beat1", data1, {fb(31), fb(21), fb(11), fb(1)});
                chk16("t1_addr1", addr1, 16'h0104);
            end
            if (c == 3) begin
                chk("s1_beat2", data0, {fb(23), fb(22), fb(21), fb(20)});
                chk16("s1_addr2", addr0, 16'h0102);
            end
            if (c == 4) chk16("t1_addr3", addr1, 16'h010C);
            step();
        end
        chk1("s1_busy_end", busy0, 1'b0);
        chk1("s1_done_end", done0, 1'b0);
        chk1("s1_no_overrun", ovr0, 1'b0);
        chk1("s1_sb_empty", q0.size() == 0, 1'b1);

        // Backpressure on beat 1 while array_out changes.
        capture(200, 16'h0200);
        array_ready = 1'b0;
        step();
        row_ready = 1'b0;
        array_out = ~array_out;
        held_d = data0;
        held_a = addr0;
        chk16("bp_addr1", addr0, 16'h0201);
        for (int c = 0; c < 3; c++) begin
            step();
            chk1("bp_valid", valid0, 1'b1);
            chk("bp_data_hold", data0, held_d);
            chk16("bp_addr_hold", addr0, held_a);
        end
        row_ready = 1'b1;
        step(); step(); step();
        chk1("bp_done", done0, 1'b1);
        step();
        chk1("bp_sb_empty", q0.size() == 0, 1'b1);

        // Low-then-high pulse during the stream is an overrun, not a replay.
        capture(400, 16'h0300);
        array_ready = 1'b0;
        step();
        load_mat(600);
        array_ready = 1'b1;
        step();
        chk1("ov_set", ovr0, 1'b1);
        chk1("ov_set_t", ovr1, 1'b1);
        for (int c = 0; c < 6; c++) step();
        chk1("ov_no_replay", valid0, 1'b0);
        chk1("ov_sb_empty", q0.size() == 0, 1'b1);

        // Address wrap; overrun stays set across a fresh capture.
        capture(500, 16'hFFFE);
        chk16("wrap_a0", addr0, 16'hFFFE);
        step();
        chk16("wrap_a1", addr0, 16'hFFFF);
        step();
        chk16("wrap_a2", addr0, 16'h0000);
        step();
        chk16("wrap_a3", addr0, 16'h0001);
        chk1("ov_sticky", ovr0, 1'b1);
        step(); step();

        // Asynchronous reset mid-stream, then a clean restart.
        capture(700, 16'h0400);
        step(); step();
        chk16("ar_beat2_addr", addr0, 16'h0402);
        #2 rst = 1'b1;
        #1;
        chk1("ar_valid", valid0, 1'b0);
        chk1("ar_busy", busy0, 1'b0);
        chk1("ar_overrun", ovr0, 1'b0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk1("ar_no_done", done0, 1'b0);
        rst = 1'b0;
        capture(800, 16'h0500);
        chk1("rs_clear", clear0, 1'b1);
        for (int c = 0; c < 4; c++) step();
        chk1("rs_done", done0, 1'b1);
        step();
        chk1("rs_sb0_empty", q0.size() == 0, 1'b1);
        chk1("rs_sb1_empty", q1.size() == 0, 1'b1);
        chk1("rs_overrun", ovr0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
